out_channel_tx: RTL and testbench

Output-side transmitter for the router's byte-serial packet channel. Pops one complete packet (header plus payload) from an output FIFO and drives it onto the channel with an o_ch_en frame. Computes and appends the XOR parity byte. Enforces the inter-packet gap the far-end input channel needs to finish its check phase.

---
 rtl/router_pkg.sv | 24 ++
 rtl/parity_acc.sv | 21 ++
 rtl/out_channel_tx.sv | 140 ++++++++++++++
 tb/tb_out_channel_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared channel widths, header field accessors and the
// output-channel state type used by both ends of the byte-serial link.
package router_pkg;

    localparam int DATA_SIZE       = 8;
    localparam int PKT_LENGTH_BITS = 5;
    localparam int ADDR_BITS       = DATA_SIZE - PKT_LENGTH_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_SEND,
        S_GAP
    } e_out_channel_state;

    function automatic logic [PKT_LENGTH_BITS-1:0] get_len(input logic [DATA_SIZE-1:0] hdr);
        return hdr[DATA_SIZE-1 -: PKT_LENGTH_BITS];
    endfunction

    function automatic logic [ADDR_BITS-1:0] get_addr(input logic [DATA_SIZE-1:0] hdr);
        return hdr[ADDR_BITS-1:0];
    endfunction

endpackage

// File: rtl/parity_acc.sv
// parity_acc: byte-wide XOR accumulator; clear beats load, load beats accumulate.
module parity_acc #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            acc <= '0;
        else
            acc <= clr ? '0 : load ? din : en ? acc ^ din : acc;
    end

endmodule

// File: rtl/out_channel_tx.sv
// out_channel_tx: pops one packet from the output FIFO and frames it on the
// byte channel with a trailing XOR parity byte and an enforced inter-packet gap.
module out_channel_tx #(
    parameter int DATA_SIZE       = router_pkg::DATA_SIZE,
    parameter int PKT_LENGTH_BITS = router_pkg::PKT_LENGTH_BITS,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [DATA_SIZE-1:0] i_fifo_data,
    input  logic                 i_fifo_empty,
    input  logic                 i_pkt_avail,
    input  logic                 i_dest_busy,
    input  logic                 i_clr_errors,
    output logic                 o_fifo_rd_en,
    output logic                 o_ch_en,
    output logic [DATA_SIZE-1:0] o_data_out,
    output logic                 o_busy,
    output logic                 o_pkt_sent,
    output logic                 o_len_error,
    output logic                 o_underflow_error,
    output logic                 o_error
);
    import router_pkg::*;

    localparam int CW = PKT_LENGTH_BITS + 1;
    localparam int GW = $clog2(GAP_CYCLES);

    e_out_channel_state         state, state_nxt;
    logic [PKT_LENGTH_BITS-1:0] len, len_nxt, hdr_len;
    logic [CW-1:0]              cnt, cnt_nxt, len_ext;
    logic [GW-1:0]              gap_cnt, gap_nxt;
    logic [DATA_SIZE-1:0]       out_nxt, parity;
    logic                       load_out, start, need_pop, acc_load, acc_en;
    logic                       sent_nxt, sent_d, set_len_err, set_uflow;
    logic                       clr_d, clr_pulse;

    assign hdr_len   = get_len(i_fifo_data);
    assign len_ext   = {1'b0, len};
    assign clr_pulse = i_clr_errors & ~clr_d;
    assign o_busy    = (state != S_IDLE);
    assign o_error   = o_len_error | o_underflow_error;

    parity_acc #(.W(DATA_SIZE)) u_parity (
        .i_clk (i_clk),
        .i_rstn(i_rstn),
        .clr   (state == S_IDLE),
        .load  (acc_load),
        .en    (acc_en),
        .din   (i_fifo_data),
        .acc   (parity)
    );

    // cnt is the number of bytes already handed to the output register;
    // the output register itself is the extra latency stage, so the final
    // byte is still on the channel during the first S_GAP cycle.
    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        cnt_nxt     = cnt;
        gap_nxt     = GW'(GAP_CYCLES - 2);
        out_nxt     = '0;
        load_out    = 1'b0;
        start       = 1'b0;
        need_pop    = 1'b0;
        acc_load    = 1'b0;
        acc_en      = 1'b0;
        sent_nxt    = 1'b0;
        set_len_err = 1'b0;
        case (state)
            S_IDLE: begin
                start     = i_pkt_avail & ~i_fifo_empty & ~i_dest_busy;
                state_nxt = start ? S_HDR : S_IDLE;
            end
            S_HDR: begin
                len_nxt = hdr_len;
                cnt_nxt = CW'(1);
                if (hdr_len == '0) begin
                    set_len_err = 1'b1;
                    state_nxt   = S_GAP;
                end else begin
                    load_out  = 1'b1;
                    out_nxt   = i_fifo_data;
                    acc_load  = 1'b1;
                    need_pop  = hdr_len >= PKT_LENGTH_BITS'(2);
                    state_nxt = (need_pop & i_fifo_empty) ? S_GAP : S_SEND;
                end
            end
            S_SEND: begin
                load_out = 1'b1;
                if (cnt == len_ext) begin
                    out_nxt   = parity;
                    sent_nxt  = 1'b1;
                    state_nxt = S_GAP;
                end else begin
                    out_nxt   = i_fifo_data;
                    acc_en    = 1'b1;
                    cnt_nxt   = cnt + CW'(1);
                    need_pop  = (cnt + CW'(1)) < len_ext;
                    state_nxt = (need_pop & i_fifo_empty) ? S_GAP : S_SEND;
                end
            end
            S_GAP: begin
                state_nxt = (gap_cnt == '0) ? S_IDLE : S_GAP;
                gap_nxt   = (gap_cnt == '0) ? gap_cnt : gap_cnt - GW'(1);
            end
        endcase
        o_fifo_rd_en = i_rstn & (start | (need_pop & ~i_fifo_empty));
        set_uflow    = need_pop & i_fifo_empty;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state             <= S_IDLE;
            len               <= '0;
            cnt               <= '0;
            gap_cnt           <= '0;
            o_ch_en           <= 1'b0;
            o_data_out        <= '0;
            sent_d            <= 1'b0;
            o_pkt_sent        <= 1'b0;
            clr_d             <= 1'b0;
            o_len_error       <= 1'b0;
            o_underflow_error <= 1'b0;
        end else begin
            state             <= state_nxt;
            len               <= len_nxt;
            cnt               <= cnt_nxt;
            gap_cnt           <= gap_nxt;
            o_ch_en           <= load_out;
            o_data_out        <= out_nxt;
            sent_d            <= sent_nxt;
            o_pkt_sent        <= sent_d;
            clr_d             <= i_clr_errors;
            o_len_error       <= set_len_err | (o_len_error & ~clr_pulse);
            o_underflow_error <= set_uflow | (o_underflow_error & ~clr_pulse);
        end
    end

endmodule

// File: tb/tb_out_channel_tx.sv
// tb_out_channel_tx: FIFO model plus packet-level scoreboard; a negedge monitor
// checks every channel byte, frame length, pkt_sent pulse, gap and accept latency.
module tb_out_channel_tx;

    localparam int GAP = 2;

    logic       i_clk = 1'b0;
    logic       i_rstn, i_fifo_empty, i_pkt_avail, i_dest_busy, i_clr_errors;
    logic [7:0] i_fifo_data;
    logic       o_fifo_rd_en, o_ch_en, o_busy, o_pkt_sent;
    logic       o_len_error, o_underflow_error, o_error;
    logic [7:0] o_data_out;

    out_channel_tx #(.GAP_CYCLES(GAP)) dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_fifo_data      (i_fifo_data),
        .i_fifo_empty     (i_fifo_empty),
        .i_pkt_avail      (i_pkt_avail),
        .i_dest_busy      (i_dest_busy),
        .i_clr_errors     (i_clr_errors),
        .o_fifo_rd_en     (o_fifo_rd_en),
        .o_ch_en          (o_ch_en),
        .o_data_out       (o_data_out),
        .o_busy           (o_busy),
        .o_pkt_sent       (o_pkt_sent),
        .o_len_error      (o_len_error),
        .o_underflow_error(o_underflow_error),
        .o_error          (o_error)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0, miscompares = 0;
    int pops = 0, frames = 0, last_len = 0, last_gap = 0;
    logic [7:0] q[$];
    logic [7:0] exp_bytes[$];
    int         exp_len[$];
    bit         exp_full[$];
    logic [7:0] cap[0:63];
    logic [7:0] pay[0:31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Queue a packet: header plus pay[1..keep-1]; keep < L models a short FIFO.
    task automatic send_pkt(input logic [7:0] hdr, input int keep);
        int l;
        logic [7:0] par;
        l   = int'(hdr[7:3]);
        par = hdr;
        q.push_back(hdr);
        if (l > 0) exp_bytes.push_back(hdr);
        for (int i = 1; i < keep; i++) begin
            q.push_back(pay[i]);
            exp_bytes.push_back(pay[i]);
            par ^= pay[i];
        end
        if (l > 0 && keep == l) begin
            exp_bytes.push_back(par);
            exp_len.push_back(l + 1);
            exp_full.push_back(1'b1);
        end else if (l > 0) begin
            exp_len.push_back(keep);
            exp_full.push_back(1'b0);
        end
        i_fifo_empty = 1'b0;
        i_pkt_avail  = 1'b1;
    endtask

    task automatic tick();
        logic rd;
        @(negedge i_clk);
        rd = o_fifo_rd_en;
        @(posedge i_clk);
        #1;
        if (rd) begin
            pops++;
            if (q.size() > 0) i_fifo_data = q.pop_front();
        end
        i_fifo_empty = (q.size() == 0);
        i_pkt_avail  = (q.size() > 0);
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (n < limit && !(q.size() == 0 && !o_busy && !o_ch_en && exp_len.size() == 0)) begin
            tick();
            n++;
        end
        check(name, n < limit, 1);
        repeat (3) tick();
    endtask

    bit prev_ch, h1, h2, have_prev;
    int flen, gap;

    always @(negedge i_clk) begin
        logic [8:0] eb;
        int el;
        bit ef;
        ef = 1'b0;
        if (!i_rstn) begin
            prev_ch = 0; h1 = 0; h2 = 0; have_prev = 0; flen = 0; gap = 0;
        end else begin
            check("error_or", o_error, o_len_error | o_underflow_error);
            if (o_ch_en) begin
                if (!prev_ch) begin
                    check("accept_to_first_byte", h2, 1);
                    if (have_prev) check("gap_min", gap >= GAP, 1);
                    last_gap = gap;
                    flen = 0;
                end
                eb = (exp_bytes.size() > 0) ? {1'b0, exp_bytes.pop_front()} : 9'h100;
                check("ch_byte", {1'b0, o_data_out}, eb);
                check("busy_in_frame", o_busy, 1);
                if (flen < 64) cap[flen] = o_data_out;
                flen++;
            end else begin
                check("idle_data_zero", o_data_out, 0);
                if (prev_ch) begin
                    el = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
                    ef = (exp_full.size() > 0) ? exp_full.pop_front() : 1'b0;
                    check("frame_len", flen, el);
                    frames++;
                    last_len  = flen;
                    have_prev = 1;
                    gap       = 0;
                end
                gap++;
            end
            check("pkt_sent", o_pkt_sent, (prev_ch && !o_ch_en) ? ef : 1'b0);
            h2      = h1;
            h1      = o_fifo_rd_en & ~o_busy;
            prev_ch = o_ch_en;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int p0, f0, pushed, npk, l, n;
        i_rstn = 0; i_fifo_empty = 1; i_pkt_avail = 0; i_dest_busy = 0;
        i_clr_errors = 0; i_fifo_data = 0;
        repeat (3) tick();
        check("rst_ch_en", o_ch_en, 0);
        check("rst_data", o_data_out, 0);
        check("rst_busy", o_busy, 0);
        check("rst_rd_en", o_fifo_rd_en, 0);
        check("rst_pkt_sent", o_pkt_sent, 0);
        check("rst_error", o_error, 0);
        i_rstn = 1;
        tick();

        // L=3: 1A 55 F0 then parity BF
        pay[1] = 8'h55; pay[2] = 8'hF0;
        p0 = pops; f0 = frames;
        send_pkt(8'h1A, 3);
        wait_done("t1_timeout", 200);
        check("t1_frames", frames - f0, 1);
        check("t1_len", last_len, 4);
        check("t1_b0", cap[0], 8'h1A);
        check("t1_b1", cap[1], 8'h55);
        check("t1_b2", cap[2], 8'hF0);
        check("t1_parity", cap[3], 8'hBF);
        check("t1_pops", pops - p0, 3);

        // L=1: header only, parity equals header
        p0 = pops;
        send_pkt(8'h08, 1);
        wait_done("t2_timeout", 200);
        check("t2_len", last_len, 2);
        check("t2_parity", cap[1], 8'h08);
        check("t2_pops", pops - p0, 1);
        check("t2_no_error", o_error, 0);

        // two queued L=2 packets back to back
        p0 = pops; f0 = frames;
        pay[1] = 8'hA5; send_pkt(8'h11, 2);
        pay[1] = 8'h3C; send_pkt(8'h12, 2);
        wait_done("t3_timeout", 200);
        check("t3_frames", frames - f0, 2);
        check("t3_gap_exact", last_gap, GAP);
        check("t3_pops", pops - p0, 4);
        check("t3_parity2", cap[2], 8'h12 ^ 8'h3C);

        // L=0 header: length error, no frame, then rising clear
        p0 = pops; f0 = frames;
        send_pkt(8'h03, 1);
        wait_done("t4_timeout", 200);
        check("t4_len_error", o_len_error, 1);
        check("t4_error", o_error, 1);
        check("t4_no_frame", frames - f0, 0);
        check("t4_pops", pops - p0, 1);
        i_clr_errors = 1;
        repeat (2) tick();
        check("t4_cleared", o_len_error, 0);
        check("t4_error_cleared", o_error, 0);
        i_clr_errors = 0;
        tick();

        // L=4 with only header and two payload bytes in the FIFO
        p0 = pops; f0 = frames;
        pay[1] = 8'h77; pay[2] = 8'h88;
        send_pkt(8'h25, 3);
        wait_done("t5_timeout", 200);
        check("t5_underflow", o_underflow_error, 1);
        check("t5_len", last_len, 3);
        check("t5_b2", cap[2], 8'h88);
        check("t5_pops", pops - p0, 3);
        check("t5_no_len_error", o_len_error, 0);

        // reset during byte 2 of an L=8 packet
        for (int i = 1; i < 8; i++) pay[i] = 8'($urandom);
        send_pkt(8'h40, 8);
        n = 0;
        while (!o_ch_en && n < 20) begin tick(); n++; end
        check("t6_frame_started", o_ch_en, 1);
        tick(); tick();
        #2 i_rstn = 0;
        #1;
        check("t6_ch_en", o_ch_en, 0);
        check("t6_data", o_data_out, 0);
        check("t6_busy", o_busy, 0);
        check("t6_rd_en", o_fifo_rd_en, 0);
        check("t6_errors", {o_len_error, o_underflow_error, o_error, o_pkt_sent}, 0);
        q.delete(); exp_bytes.delete(); exp_len.delete(); exp_full.delete();
        i_fifo_empty = 1; i_pkt_avail = 0; i_fifo_data = 0;
        repeat (2) tick();
        i_rstn = 1;
        tick();
        check("t6_idle_after", o_busy, 0);

        // destination busy holds the FSM in S_IDLE
        i_dest_busy = 1;
        send_pkt(8'h09, 1);
        p0 = pops;
        repeat (6) tick();
        check("t7_no_pop", pops - p0, 0);
        check("t7_idle", o_busy, 0);
        i_dest_busy = 0;
        wait_done("t7_timeout", 200);
        check("t7_pops", pops - p0, 1);
        check("t7_parity", cap[1], 8'h09);

        // random traffic with random far-end backpressure
        p0 = pops; f0 = frames; pushed = 0; npk = 0;
        for (int c = 0; c < 1500; c++) begin
            if (npk < 40 && q.size() < 64 && $urandom_range(0, 3) == 0) begin
                l = $urandom_range(1, 31);
                for (int i = 1; i < l; i++) pay[i] = 8'($urandom);
                send_pkt({5'(l), 3'($urandom_range(0, 7))}, l);
                pushed += l;
                npk++;
            end
            i_dest_busy = ($urandom_range(0, 9) < 3);
            tick();
        end
        i_dest_busy = 0;
        wait_done("rand_timeout", 8000);
        check("rand_pops", pops - p0, pushed);
        check("rand_frames", frames - f0, npk);
        check("rand_no_error", o_error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
